l1_mem_responder: RTL
=====================

# l1_mem_responder

Memory-side responder for the L1 cache's `cache2mem_*` / `mem2cache_*` message interface. It accepts line-fill reads and line write-backs issued by the cache controller. It then serialises each cache line into word transactions on a simple request/grant main-memory port and returns `MEM_RESP` / `MEM_READY` to the cache. In single-core builds it sits directly below one L1 in place of the bus/NoC interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDRESS_BITS`, 32: word address width.
- `CACHE_OFFSET_BITS`, 2: log2 of words per line.
- `MSG_BITS`, 4: message field width.
- `CACHE_WORDS`, `1<<CACHE_OFFSET_BITS`: derived; keep the default.
- `CACHE_WIDTH`, `DATA_WIDTH*CACHE_WORDS`: derived; keep the default.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cache2mem_msg`  in  MSG_BITS  request from the cache.
- `cache2mem_address`  in  ADDRESS_BITS  line address; the offset bits are ignored.
- `cache2mem_data`  in  CACHE_WIDTH  write-back line.
- `mem2cache_msg`  out  MSG_BITS  response message.
- `mem2cache_address`  out  ADDRESS_BITS  echoed line address, offset bits zero.
- `mem2cache_data`  out  CACHE_WIDTH  fill line.
- `mem_req`  out  1  word command valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDRESS_BITS  word address.
- `mem_wdata`  out  DATA_WIDTH  write word.
- `mem_gnt`  in  1  command accepted this cycle.
- `mem_rvalid`  in  1  read word returned.
- `mem_rdata`  in  DATA_WIDTH  read word.
- `rd_count`  out  32  number of completed fills.
- `wb_count`  out  32  number of completed write-backs.

## Operation
Message encodings:
- Requests: `NO_REQ`=0, `R_REQ`=1, `WB_REQ`=2, `FLUSH`=3. `FLUSH` is serviced identically to `WB_REQ`.
- Responses: `NO_MSG`=0, `MEM_RESP`=4, `MEM_READY`=5.

Request acceptance:
- A request is accepted only in `IDLE`.
- On acceptance the block latches the address (offset bits forced to 0), the request type and the data, then clears the word index.
- Any other message value in `IDLE` is ignored.
- Changes to the cache inputs after acceptance are ignored until the block returns to `IDLE`.

State machine:
- `IDLE`: `R_REQ` goes to `RD_ISSUE`; `WB_REQ` or `FLUSH` goes to `WR_ISSUE`.
- `RD_ISSUE`: drives `mem_req`=1, `mem_we`=0, `mem_addr`={line, idx}. On `mem_gnt` it moves to `RD_WAIT`.
- `RD_WAIT`: on `mem_rvalid`, stores `mem_rdata` into word slot idx of the line buffer (word 0 occupies the LSBs). If idx was the last word it moves to `RESP`; otherwise it increments idx and returns to `RD_ISSUE`.
- `WR_ISSUE`: drives `mem_req`=1, `mem_we`=1, `mem_wdata`=word idx of the latched line. On `mem_gnt` at the last idx it moves to `RESP`; on any other `mem_gnt` it increments idx and stays.
- `RESP`: drives `mem2cache_msg` (`MEM_RESP` for a read, `MEM_READY` for a write) and `mem2cache_address`. `mem2cache_data` carries the line buffer for reads and 0 for writes. When `cache2mem_msg`==`NO_REQ` it moves to `IDLE`. All `mem2cache_*` outputs return to 0 in the cycle after that exit.

Rules:
- Only one memory command is outstanding at a time.
- `mem_rvalid` outside `RD_WAIT` is ignored.
- `mem_req` stays asserted with stable command fields until `mem_gnt`.
- The word index is CACHE_OFFSET_BITS wide and its final increment wraps to 0.
- The response is held for as long as the cache keeps its request asserted. This prevents servicing the same request twice.

Reset:
- Reset asserted at any time, including mid-line, forces `IDLE` asynchronously and drops `mem_req` immediately.
- All outputs, the line buffer, the index and the counters reset to 0.
- No partial response is ever produced.

## Timing
- All outputs are registered.
- Read example with zero-wait memory (`mem_gnt` in the same cycle as `mem_req`, `mem_rvalid` one cycle later) and 4 words, `R_REQ` sampled at edge 0:
  - `mem_req` high in cycles 1, 3, 5, 7.
  - `mem_rvalid` in cycles 2, 4, 6, 8.
  - `MEM_RESP` visible from cycle 9.
- Write-back with `mem_gnt` tied to 1: words are issued in cycles 1–4 and `MEM_READY` is visible from cycle 5.
- Each stall cycle on `mem_gnt` or `mem_rvalid` adds exactly one cycle.
- Earliest re-acceptance is 2 cycles after `NO_REQ` is first sampled in `RESP`: one cycle to return to `IDLE`, one cycle in `IDLE`.

## Configuration
- Macro `L1_MEM_RESPONDER_STATS_EN`.
- Defined: `rd_count` and `wb_count` each increment by 1 on the `RESP`→`IDLE` transition of a read or write respectively. Both saturate at 2^32−1 and reset to 0.
- Undefined: the counters are not built, and both ports are tied to 0.

## Structure
- Package `l1_mem_pkg`:
  - message encoding localparams (shared with the cache controller);
  - state enum `resp_state_t`.
- Sub-module `line_word_buffer`: a CACHE_WIDTH register with word-indexed write and read, plus bulk load from the request.

## Test plan
- Fill: `R_REQ` at address 0x104, memory returns 0xA0..0xA3 at zero wait. Required: `mem_addr` sequence 0x104–0x107, `mem2cache_data`=0x000000A3_000000A2_000000A1_000000A0, `MEM_RESP` in cycle 9, address 0x104.
- Write-back: `WB_REQ` at 0x20 with line {0x4,0x3,0x2,0x1} and `mem_gnt` low for 2 cycles per word. Required: `mem_wdata` 1, 2, 3, 4 to addresses 0x20–0x23, each held stable while waiting; `MEM_READY` follows.
- Held request: the cache keeps `R_REQ` for 5 cycles after `MEM_RESP`. Required: no new `mem_req`, response held; outputs 0 and `IDLE` 2 cycles after `NO_REQ`.
- Reset mid-line: reset pulsed after the 2nd read word. Required: `mem_req`=0 asynchronously, all outputs 0; a new `R_REQ` is then serviced from word 0.
- Noise: message 0x7 in `IDLE`, plus a spurious `mem_rvalid` in `IDLE`. Required: no state change and no memory command.
- Stats (macro defined): 3 fills and 2 write-backs. Required: `rd_count`=3, `wb_count`=2. With the macro undefined both read 0.

Source files
------------

// File: rtl/l1_mem_pkg.sv
// rtl/l1_mem_pkg.sv - message encodings and responder state type shared with the L1 controller
package l1_mem_pkg;

  // Cache -> memory request messages
  localparam int unsigned NO_REQ    = 0;
  localparam int unsigned R_REQ     = 1;
  localparam int unsigned WB_REQ    = 2;
  localparam int unsigned FLUSH     = 3;

  // Memory -> cache response messages
  localparam int unsigned NO_MSG    = 0;
  localparam int unsigned MEM_RESP  = 4;
  localparam int unsigned MEM_READY = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } resp_state_t;

endpackage

// File: rtl/line_word_buffer.sv
// rtl/line_word_buffer.sv - one cache line register with bulk load and word-indexed write/read
module line_word_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          load_en,
  input  logic [DATA_WIDTH*(1<<CACHE_OFFSET_BITS)-1:0]  load_line,
  input  logic                                          wr_en,
  input  logic [CACHE_OFFSET_BITS-1:0]                  wr_idx,
  input  logic [DATA_WIDTH-1:0]                         wr_word,
  input  logic [CACHE_OFFSET_BITS-1:0]                  rd_idx,
  output logic [DATA_WIDTH-1:0]                         rd_word,
  output logic [DATA_WIDTH*(1<<CACHE_OFFSET_BITS)-1:0]  line
);

  // Bulk load wins over a word write; word 0 sits in the LSBs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line <= '0;
    end else if (load_en) begin
      line <= load_line;
    end else if (wr_en) begin
      line[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= wr_word;
    end
  end

  assign rd_word = line[rd_idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/l1_mem_responder.sv
// rtl/l1_mem_responder.sv - L1 line fill/write-back responder over a word req/gnt port (stats: L1_MEM_RESPONDER_STATS_EN)
module l1_mem_responder
  import l1_mem_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int MSG_BITS          = 4,
  parameter int CACHE_WORDS       = 1 << CACHE_OFFSET_BITS,
  parameter int CACHE_WIDTH       = DATA_WIDTH * CACHE_WORDS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache2mem_msg,
  input  logic [ADDRESS_BITS-1:0] cache2mem_address,
  input  logic [CACHE_WIDTH-1:0]  cache2mem_data,
  output logic [MSG_BITS-1:0]     mem2cache_msg,
  output logic [ADDRESS_BITS-1:0] mem2cache_address,
  output logic [CACHE_WIDTH-1:0]  mem2cache_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [31:0]             rd_count,
  output logic [31:0]             wb_count
);

  localparam int OB = CACHE_OFFSET_BITS;
  localparam logic [MSG_BITS-1:0] M_NO_REQ    = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_R_REQ     = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] M_WB_REQ    = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] M_FLUSH     = MSG_BITS'(FLUSH);
  localparam logic [MSG_BITS-1:0] M_NO_MSG    = MSG_BITS'(NO_MSG);
  localparam logic [MSG_BITS-1:0] M_MEM_RESP  = MSG_BITS'(MEM_RESP);
  localparam logic [MSG_BITS-1:0] M_MEM_READY = MSG_BITS'(MEM_READY);
  localparam logic [OB-1:0]       LAST_IDX    = OB'(CACHE_WORDS - 1);

  resp_state_t             state_q, state_d;
  logic [OB-1:0]           idx_q, idx_d, idx_inc;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic                    is_rd_q, is_rd_d;

  logic                    mem_req_d, mem_we_d;
  logic [ADDRESS_BITS-1:0] mem_addr_d, rsp_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;
  logic [MSG_BITS-1:0]     msg_d;
  logic [CACHE_WIDTH-1:0]  rsp_data_d;

  logic                    buf_load, buf_wr;
  logic [DATA_WIDTH-1:0]   buf_rd_word;
  logic [CACHE_WIDTH-1:0]  buf_line, fill_line;

  logic [ADDRESS_BITS-1:0] req_line, next_word_addr;
  logic                    unused_offset;
  logic                    resp_exit;

  // The cache may present any offset; only the line part is kept
  assign req_line       = {cache2mem_address[ADDRESS_BITS-1:OB], {OB{1'b0}}};
  assign unused_offset  = ^cache2mem_address[OB-1:0];
  assign idx_inc        = idx_q + OB'(1);
  assign next_word_addr = {addr_q[ADDRESS_BITS-1:OB], idx_inc};
  assign resp_exit      = (state_q == RESP) && (cache2mem_msg == M_NO_REQ);

  line_word_buffer #(
    .DATA_WIDTH        (DATA_WIDTH),
    .CACHE_OFFSET_BITS (CACHE_OFFSET_BITS)
  ) u_line_buf (
    .clock     (clock),
    .reset     (reset),
    .load_en   (buf_load),
    .load_line (cache2mem_data),
    .wr_en     (buf_wr),
    .wr_idx    (idx_q),
    .wr_word   (mem_rdata),
    .rd_idx    (idx_inc),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

  // Line as it will look once the word arriving this cycle is merged in,
  // so the fill response can be registered on the same edge as the last word
  always_comb begin
    fill_line = buf_line;
    fill_line[idx_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    is_rd_d     = is_rd_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    msg_d       = mem2cache_msg;
    rsp_addr_d  = mem2cache_address;
    rsp_data_d  = mem2cache_data;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cache2mem_msg == M_R_REQ || cache2mem_msg == M_WB_REQ || cache2mem_msg == M_FLUSH) begin
          addr_d     = req_line;
          idx_d      = '0;
          is_rd_d    = (cache2mem_msg == M_R_REQ);
          buf_load   = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = req_line;
          if (cache2mem_msg == M_R_REQ) begin
            state_d     = RD_ISSUE;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end else begin
            // Buffer is only loaded on this edge, so word 0 comes straight from the input
            state_d     = WR_ISSUE;
            mem_we_d    = 1'b1;
            mem_wdata_d = cache2mem_data[DATA_WIDTH-1:0];
          end
        end
      end
      RD_ISSUE: begin
        if (mem_gnt) begin
          state_d    = RD_WAIT;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          buf_wr = 1'b1;
          idx_d  = idx_inc;
          if (idx_q == LAST_IDX) begin
            state_d    = RESP;
            msg_d      = M_MEM_RESP;
            rsp_addr_d = addr_q;
            rsp_data_d = fill_line;
          end else begin
            state_d    = RD_ISSUE;
            mem_req_d  = 1'b1;
            mem_addr_d = next_word_addr;
          end
        end
      end
      WR_ISSUE: begin
        if (mem_gnt) begin
          idx_d = idx_inc;
          if (idx_q == LAST_IDX) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            msg_d       = M_MEM_READY;
            rsp_addr_d  = addr_q;
            rsp_data_d  = '0;
          end else begin
            mem_addr_d  = next_word_addr;
            mem_wdata_d = buf_rd_word;
          end
        end
      end
      RESP: begin
        // Holding until NO_REQ keeps a still-asserted request from being serviced twice
        if (cache2mem_msg == M_NO_REQ) begin
          state_d    = IDLE;
          msg_d      = M_NO_MSG;
          rsp_addr_d = '0;
          rsp_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and all outputs; reset drops mem_req at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      addr_q            <= '0;
      is_rd_q           <= 1'b0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem2cache_msg     <= '0;
      mem2cache_address <= '0;
      mem2cache_data    <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      addr_q            <= addr_d;
      is_rd_q           <= is_rd_d;
      mem_req           <= mem_req_d;
      mem_we            <= mem_we_d;
      mem_addr          <= mem_addr_d;
      mem_wdata         <= mem_wdata_d;
      mem2cache_msg     <= msg_d;
      mem2cache_address <= rsp_addr_d;
      mem2cache_data    <= rsp_data_d;
    end
  end

`ifdef L1_MEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q, wb_cnt_q;

  // Count completed transactions when the cache releases the response; saturate at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wb_cnt_q <= '0;
    end else if (resp_exit) begin
      if (is_rd_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (!is_rd_q && wb_cnt_q != '1) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wb_count = wb_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = resp_exit;
  assign rd_count     = '0;
  assign wb_count     = '0;
`endif

endmodule
